// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the tile-map VRAM arbiter, tile renderer and game logic.
// Holds the arbiter FSM state encoding and the default tile-map geometry.
package vram_arbiter_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 4;

    typedef enum logic [1:0] {
        WAIT_EOF = 2'd0,
        WINDOW   = 2'd1,
        CLOSE    = 2'd2
    } state_t;

endpackage

// File: rtl/vram_arbiter_rr_picker.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
// Purely combinational; the caller owns and advances the pointer.
module rr_picker #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   index,
    output logic            any
);

    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                index      = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one synchronous single-port tile-map RAM between the display pipeline
// (absolute priority) and game requesters, which may only access it between EOF and SOF.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              SOF,
    input  logic              EOF,
    input  logic              disp_req,
    input  logic [AW-1:0]     disp_addr,
    output logic [DW-1:0]     disp_data,
    output logic              disp_valid,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [DW-1:0]     rdata,
    output logic [NREQ-1:0]   rvalid,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata,
    output logic              window_open,
    output logic [15:0]       grant_count,
    output state_t            state,
    output logic [PW-1:0]     ptr
);

    state_t          state_next;
    logic [NREQ-1:0] pick_grant;
    logic [PW-1:0]   pick_index;
    logic            pick_any;
    logic            game_go;
    logic [AW-1:0]   sel_addr;
    logic            sel_we;
    logic [DW-1:0]   sel_wdata;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .index (pick_index),
        .any   (pick_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_index == PW'(i)) begin
                sel_addr  = addr[i*AW +: AW];
                sel_we    = we[i];
                sel_wdata = wdata[i*DW +: DW];
            end
        end
    end

    // SOF dominates EOF so a coincident pair never opens a window.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_EOF: if (EOF && !SOF) state_next = WINDOW;
            WINDOW:   if (SOF) state_next = CLOSE;
            CLOSE:    state_next = WAIT_EOF;
            default:  state_next = WAIT_EOF;
        endcase
    end

    always_comb begin
        game_go     = (state == WINDOW) && !disp_req && pick_any;
        gnt         = game_go ? pick_grant : '0;
        window_open = (state == WINDOW);
        ram_we      = game_go && sel_we;
        ram_wdata   = game_go ? sel_wdata : wdata_q;
        if (disp_req)     ram_addr = disp_addr;
        else if (game_go) ram_addr = sel_addr;
        else              ram_addr = addr_q;
        disp_data = disp_valid ? ram_rdata : '0;
        rdata     = (|rvalid)  ? ram_rdata : '0;
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state       <= WAIT_EOF;
            ptr         <= '0;
            rvalid      <= '0;
            disp_valid  <= 1'b0;
            grant_count <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state      <= state_next;
            disp_valid <= disp_req;
            rvalid     <= (game_go && !sel_we) ? pick_grant : '0;
            if (disp_req || game_go) addr_q <= ram_addr;
            if (game_go) begin
                wdata_q <= sel_wdata;
                ptr     <= (pick_index == PW'(NREQ-1)) ? '0 : pick_index + 1'b1;
            end
            if (state != WINDOW && state_next == WINDOW)
                grant_count <= '0;
            else if (game_go && grant_count != 16'hFFFF)
                grant_count <= grant_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and directed bench for vram_arbiter against a frame-window
// reference model with a shadow copy of the tile RAM.
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 8;
    localparam int DW   = 4;
    localparam int PW   = 2;

    logic              clock_50 = 1'b0;
    logic              reset, SOF, EOF, disp_req;
    logic [AW-1:0]     disp_addr;
    logic [DW-1:0]     disp_data;
    logic              disp_valid;
    logic [NREQ-1:0]   req, we, gnt, rvalid;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [DW-1:0]     rdata, ram_wdata;
    logic [DW-1:0]     ram_rdata = '0;
    logic [AW-1:0]     ram_addr;
    logic              ram_we, window_open;
    logic [15:0]       grant_count;
    state_t            state;
    logic [PW-1:0]     ptr;

    always #5 clock_50 = ~clock_50;

    vram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock_50(clock_50), .reset(reset), .SOF(SOF), .EOF(EOF),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_valid(disp_valid), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .window_open(window_open), .grant_count(grant_count),
        .state(state), .ptr(ptr)
    );

    // Tile RAM: stored words are xor-scrambled so an unwritten cell reads scr(addr).
    function automatic logic [DW-1:0] scr(input int a);
        return DW'(a * 5 + 3);
    endfunction

    logic [DW-1:0] mem [256] = '{default: '0};
    always @(posedge clock_50) begin
        if (ram_we) mem[ram_addr] <= ram_wdata ^ scr(int'(ram_addr));
        ram_rdata <= mem[ram_addr] ^ scr(int'(ram_addr));
    end

    // Reference model: window/close phase flags, pointer, count, pending returns.
    bit              m_win, m_close, m_dvalid;
    int              m_ptr, m_count;
    logic [AW-1:0]   m_last_addr;
    logic [NREQ-1:0] m_rvalid;
    logic [DW-1:0]   m_rdata, m_ddata;
    logic [DW-1:0]   shadow [256];
    int              n_vec = 0;
    int              n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win = 0; m_close = 0; m_dvalid = 0; m_ptr = 0; m_count = 0;
        m_last_addr = '0; m_rvalid = '0; m_rdata = '0; m_ddata = '0;
    endtask

    // Inputs are already set (after a falling edge); check, then advance one cycle.
    task automatic tick();
        int              gi;
        logic [NREQ-1:0] e_gnt;
        logic [AW-1:0]   e_addr;
        logic            e_we;
        logic [DW-1:0]   e_wd;
        #1;
        gi = -1;
        if (m_win && !disp_req) begin
            for (int k = 0; k < NREQ; k++) begin
                int p;
                p = (m_ptr + k) % NREQ;
                if (gi < 0 && req[p]) gi = p;
            end
        end
        e_gnt = '0;
        if (gi >= 0) e_gnt[gi] = 1'b1;
        e_we   = (gi >= 0) && we[gi];
        e_wd   = (gi >= 0) ? wdata[gi*DW +: DW] : '0;
        e_addr = disp_req ? disp_addr : ((gi >= 0) ? addr[gi*AW +: AW] : m_last_addr);

        check("window_open", 32'(window_open), 32'(m_win));
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("ram_we", 32'(ram_we), 32'(e_we));
        check("ram_addr", 32'(ram_addr), 32'(e_addr));
        if (e_we) check("ram_wdata", 32'(ram_wdata), 32'(e_wd));
        check("rvalid", 32'(rvalid), 32'(m_rvalid));
        if (m_rvalid != 0) check("rdata", 32'(rdata), 32'(m_rdata));
        check("disp_valid", 32'(disp_valid), 32'(m_dvalid));
        if (m_dvalid) check("disp_data", 32'(disp_data), 32'(m_ddata));
        check("grant_count", 32'(grant_count), 32'(m_count));
        check("ptr", 32'(ptr), 32'(m_ptr));

        @(posedge clock_50);
        if (reset) begin
            model_reset();
        end else begin
            m_rvalid = (gi >= 0 && !e_we) ? e_gnt : '0;
            m_rdata  = shadow[e_addr];
            m_dvalid = disp_req;
            m_ddata  = shadow[disp_addr];
            if (gi >= 0) begin
                m_ptr = (gi + 1) % NREQ;
                if (m_count < 65535) m_count++;
            end
            if (disp_req || gi >= 0) m_last_addr = e_addr;
            if (m_win) begin
                if (SOF) begin m_win = 0; m_close = 1; end
            end else if (m_close) begin
                m_close = 0;
            end else if (EOF && !SOF) begin
                m_win = 1; m_count = 0;
            end
        end
        if (e_we) shadow[e_addr] = e_wd;
        @(negedge clock_50);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = scr(i);
        model_reset();
        reset = 1'b1; SOF = 0; EOF = 0; disp_req = 0; disp_addr = '0;
        req = '0; we = '0; addr = '0; wdata = '0;
        @(negedge clock_50);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Round-robin over three readers after the window opens.
        EOF = 1; tick(); EOF = 0;
        req = 3'b111; we = 3'b000; addr = {8'h30, 8'h20, 8'h10};
        repeat (4) tick();
        req = '0; tick();

        // Display priority blocks requester 1 for three cycles.
        req = 3'b010; disp_req = 1; disp_addr = 8'h55;
        repeat (3) tick();
        disp_req = 0; tick();
        req = '0; tick();
        SOF = 1; tick(); SOF = 0; tick();

        // Write held in WAIT_EOF, granted once the window opens; read it back.
        req = 3'b001; we = 3'b001; addr[7:0] = 8'h77; wdata[3:0] = 4'hA;
        repeat (3) tick();
        EOF = 1; tick(); EOF = 0;
        tick();
        req = '0; we = '0; tick();
        req = 3'b001; tick(); req = '0; tick();

        // SOF+EOF together closes the open window, then fails to open one.
        SOF = 1; EOF = 1; tick(); SOF = 0; EOF = 0; tick();
        SOF = 1; EOF = 1; tick(); SOF = 0; EOF = 0; tick(); tick();

        // Read granted on the SOF cycle returns during CLOSE.
        EOF = 1; tick(); EOF = 0;
        req = 3'b100; we = '0; addr[23:16] = 8'h9C; SOF = 1; tick(); SOF = 0;
        tick(); tick(); req = '0; tick();

        // Reset with a read granted: nothing returns afterwards.
        EOF = 1; tick(); EOF = 0;
        req = 3'b010; addr[15:8] = 8'h42; reset = 1; tick();
        reset = 0; req = '0; tick(); tick();

        for (int n = 0; n < 2000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            SOF       = ($urandom_range(0, 19) == 0);
            EOF       = ($urandom_range(0, 11) == 0);
            disp_req  = ($urandom_range(0, 2) == 0);
            disp_addr = AW'($urandom);
            req       = NREQ'($urandom);
            we        = NREQ'($urandom);
            addr      = (NREQ*AW)'($urandom);
            wdata     = (NREQ*DW)'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of game-logic requesters (players, bomb engine).
REQ-002 Parameter AW, default 8: tile-map address width.
REQ-003 Parameter DW, default 4: tile-code width.
REQ-004 clock_50  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 SOF, EOF  in  1 each  single-cycle frame markers from the sync generator.
REQ-007 disp_req  in  1  display pipeline read request.
REQ-008 disp_addr  in  AW  display read address.
REQ-009 disp_data  out  DW  display read data.
REQ-010 disp_valid  out  1  display data valid.
REQ-011 req  in  NREQ  per-requester request, held until granted.
REQ-012 we  in  NREQ  per-requester write-enable (0 = read).
REQ-013 addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
REQ-014 wdata  in  NREQ*DW  packed write data.
REQ-015 gnt  out  NREQ  one-hot grant pulse.
REQ-016 rdata  out  DW  read data for game requesters.
REQ-017 rvalid  out  NREQ  one-hot read-data valid.
REQ-018 ram_addr, ram_we, ram_wdata  out  AW, 1, DW  single-port synchronous RAM controls.
REQ-019 ram_rdata  in  DW  RAM read data, one cycle after address.
REQ-020 window_open  out  1  high while game access is permitted.
REQ-021 grant_count  out  16  number of game grants in the current or last window.

Function
REQ-022 The FSM SHALL have states WAIT_EOF, WINDOW, CLOSE.
REQ-023 WAIT_EOF -> WINDOW on EOF; WINDOW -> CLOSE on SOF; CLOSE -> WAIT_EOF after exactly one cycle.
REQ-024 window_open SHALL be 1 only in WINDOW.
REQ-025 When SOF and EOF are both high in the same cycle, SOF SHALL win: no window opens, and an open window closes.
REQ-026 The display SHALL have absolute priority: disp_req=1 drives ram_addr=disp_addr and ram_we=0 in that cycle, in any state.
REQ-027 disp_valid SHALL pulse exactly one cycle after each accepted disp_req, with disp_data=ram_rdata.
REQ-028 A game grant SHALL be issued only when the state is WINDOW, disp_req=0, and at least one req bit is set.
REQ-029 At most one gnt bit SHALL be set per cycle.
REQ-030 The RAM access SHALL occur in the grant cycle, using the granted requester's addr, we and wdata.
REQ-031 Arbitration SHALL be round-robin: search starts at ptr, and ptr becomes (granted index + 1) mod NREQ after a grant.
REQ-032 ptr SHALL be unchanged in cycles with no grant, including cycles blocked by display priority.
REQ-033 For a granted read, rvalid[i] SHALL pulse one cycle after gnt[i], with rdata=ram_rdata.
REQ-034 A granted write SHALL produce no rvalid.
REQ-035 A read granted in the last WINDOW cycle SHALL still return its data during CLOSE.
REQ-036 grant_count SHALL clear on entry to WINDOW, increment on each game grant, and saturate at 16'hFFFF.
REQ-037 With no access in a cycle, ram_we SHALL be 0 and ram_addr SHALL hold its previous value.

Reset
REQ-038 On reset, state SHALL be WAIT_EOF and ptr SHALL be 0.
REQ-039 On reset, gnt, rvalid, disp_valid, ram_we, window_open, grant_count, ram_addr, ram_wdata, rdata and disp_data SHALL be 0.
REQ-040 Reset asserted mid-window SHALL discard any in-flight read; no rvalid appears after reset.

Structure
REQ-041 A shared package SHALL hold the FSM state enum and the default AW/DW constants, for reuse by the tile renderer and game logic.
REQ-042 The round-robin priority picker SHALL be one sub-module, rr_picker (inputs req, ptr; outputs one-hot grant, index, any).

Verification
REQ-043 Reset, then EOF pulse, then req=3'b111 all reads -> gnt 001, 010, 100, 001 on consecutive cycles; each rvalid one cycle later.
REQ-044 In WINDOW, disp_req=1 for 3 cycles with req[1]=1 -> no gnt for 3 cycles, ptr unchanged, gnt[1] on the 4th cycle.
REQ-045 In WAIT_EOF, req[0]=1 write -> no gnt and ram_we=0 until EOF; gnt[0] in the cycle after EOF.
REQ-046 SOF and EOF in the same cycle while in WAIT_EOF -> window_open stays 0.
REQ-047 Read gnt[2] coincident with SOF -> rvalid[2] during CLOSE; no further grants; grant_count holds its value.
REQ-048 reset asserted in WINDOW with a read in flight -> next cycle all outputs 0 and no rvalid.
